// File: rtl/keypad_operand_ctrl_if.sv
// Keypad operand controller bus: scanner key strobe in, operand pair out.
// master: the operand controller; slave: the scanner/arithmetic side.
interface keypad_operand_ctrl_if #(
  parameter int OP_W = 8
) ();
  logic [3:0]             key_code;
  logic                   key_valid;
  logic signed [OP_W-1:0] op_a;
  logic signed [OP_W-1:0] op_b;
  logic                   op_valid;
  logic                   op_ready;

  modport master (
    input  key_code, key_valid, op_ready,
    output op_a, op_b, op_valid
  );

  modport slave (
    output key_code, key_valid, op_ready,
    input  op_a, op_b, op_valid
  );
endinterface

// File: rtl/keypad_operand_ctrl.sv
// Keypad operand controller: debounces scanner strobes, assembles two signed
// decimal operands and hands them downstream over valid/ready.
// Optional feature macro: KEYPAD_OPERAND_AUTOENTER_EN (commit on the last
// allowed digit instead of waiting for the enter key).
module keypad_operand_ctrl #(
  parameter int OP_W        = 8,
  parameter int MAX_DIGITS  = 2,
  parameter int RELEASE_CYC = 8
) (
  input  logic                               clk_div,
  input  logic                               rst,
  keypad_operand_ctrl_if.master              bus,
  output logic signed [OP_W-1:0]             entry,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_cnt,
  output logic                               entering_b,
  output logic                               ovf
);
  localparam int CW = $clog2(MAX_DIGITS+1);
  localparam int RW = $clog2(RELEASE_CYC+1);

  localparam logic [3:0] KEY_SIGN  = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;
  localparam logic [3:0] KEY_CLEAR = 4'd12;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, ISSUE} state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   mag_q, mag_d, mag_next;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic signed [OP_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic              armed_q;
  logic [RW-1:0]     rel_cnt_q;
  logic              accept;

  // Sign-magnitude to two's complement; negative zero folds to zero.
  function automatic logic signed [OP_W-1:0] apply_sign(input logic [OP_W-1:0] m,
                                                        input logic n);
    return n ? -$signed(m) : $signed(m);
  endfunction

  assign accept   = bus.key_valid & armed_q;
  assign mag_next = (mag_q * OP_W'(10)) + OP_W'(bus.key_code);

  assign entry      = apply_sign(mag_q, neg_q);
  assign digit_cnt  = cnt_q;
  assign ovf        = ovf_q;
  assign entering_b = (state_q != ENTER_A);
  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.op_valid = (state_q == ISSUE);

  // Key lockout: one acceptance per press, re-armed after RELEASE_CYC quiet cycles.
  always_ff @(posedge clk_div) begin
    if (rst) begin
      armed_q   <= 1'b1;
      rel_cnt_q <= '0;
    end else if (bus.key_valid) begin
      armed_q   <= 1'b0;
      rel_cnt_q <= '0;
    end else if (!armed_q) begin
      if (rel_cnt_q == RW'(RELEASE_CYC-1)) begin
        armed_q   <= 1'b1;
        rel_cnt_q <= '0;
      end else begin
        rel_cnt_q <= rel_cnt_q + 1'b1;
      end
    end
  end

  // State and entry registers.
  always_ff @(posedge clk_div) begin
    if (rst) begin
      state_q <= ENTER_A;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  // Key decode, operand commit and next-state selection.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    unique case (state_q)
      ENTER_A, ENTER_B: begin
        if (accept) begin
          if (bus.key_code <= 4'd9) begin
            if (cnt_q < CW'(MAX_DIGITS)) begin
              mag_d = mag_next;
              cnt_d = cnt_q + 1'b1;
`ifdef KEYPAD_OPERAND_AUTOENTER_EN
              // Last allowed digit commits immediately, sign already applied.
              if (cnt_q == CW'(MAX_DIGITS-1)) begin
                ovf_d = 1'b0;
                if (state_q == ENTER_A) begin
                  op_a_d  = apply_sign(mag_next, neg_q);
                  mag_d   = '0;
                  neg_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = ENTER_B;
                end else begin
                  op_b_d  = apply_sign(mag_next, neg_q);
                  state_d = ISSUE;
                end
              end
`endif
            end else begin
              ovf_d = 1'b1;
            end
          end else if (bus.key_code == KEY_SIGN) begin
            neg_d = ~neg_q;
          end else if (bus.key_code == KEY_ENTER && cnt_q != '0) begin
            ovf_d = 1'b0;
            if (state_q == ENTER_A) begin
              op_a_d  = entry;
              mag_d   = '0;
              neg_d   = 1'b0;
              cnt_d   = '0;
              state_d = ENTER_B;
            end else begin
              op_b_d  = entry;
              state_d = ISSUE;
            end
          end else if (bus.key_code == KEY_CLEAR) begin
            // Clear on an empty second entry backs out to the first operand.
            if (state_q == ENTER_B && cnt_q == '0 && !neg_q) begin
              op_a_d  = '0;
              state_d = ENTER_A;
            end
            mag_d = '0;
            neg_d = 1'b0;
            cnt_d = '0;
            ovf_d = 1'b0;
          end
        end
      end
      ISSUE: begin
        // Keys are ignored here; only the transfer leaves this state.
        if (bus.op_ready) begin
          state_d = ENTER_A;
          mag_d   = '0;
          neg_d   = 1'b0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ENTER_A;
    endcase
  end
endmodule

// File: tb/tb_keypad_operand_ctrl.sv
// Directed bench for keypad_operand_ctrl (default build, RELEASE_CYC=8).
module tb_keypad_operand_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic signed [7:0] entry;
  logic [1:0]        digit_cnt;
  logic              entering_b;
  logic              ovf;
  int total = 0;
  int bad   = 0;

  keypad_operand_ctrl_if #(.OP_W(8)) bus ();

  keypad_operand_ctrl #(.OP_W(8), .MAX_DIGITS(2), .RELEASE_CYC(8)) dut (
    .clk_div   (clk),
    .rst       (rst),
    .bus       (bus),
    .entry     (entry),
    .digit_cnt (digit_cnt),
    .entering_b(entering_b),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [3:0] code);
    bus.key_code  = code;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] code);
    strobe(code);
    gap(8);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.key_code  = 4'd0;
    bus.key_valid = 1'b0;
    bus.op_ready  = 1'b0;
    rst = 1'b1;
    gap(2);
    check("rst_op_a", $unsigned(bus.op_a), 8'h00);
    check("rst_op_b", $unsigned(bus.op_b), 8'h00);
    check("rst_valid", bus.op_valid, 1'b0);
    check("rst_entry", $unsigned(entry), 8'h00);
    check("rst_cnt", digit_cnt, 2'd0);
    check("rst_entb", entering_b, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    gap(1);

    // Basic pair 42, -7 with downstream ready
    bus.op_ready = 1'b1;
    press(4'd4);
    check("t1_entry4", $unsigned(entry), 8'd4);
    check("t1_cnt1", digit_cnt, 2'd1);
    press(4'd2);
    check("t1_entry42", $unsigned(entry), 8'd42);
    check("t1_cnt2", digit_cnt, 2'd2);
    press(4'd11);
    check("t1_op_a", $unsigned(bus.op_a), 8'd42);
    check("t1_entb", entering_b, 1'b1);
    check("t1_entry_clr", $unsigned(entry), 8'd0);
    press(4'd10);
    check("t1_negzero", $unsigned(entry), 8'd0);
    press(4'd7);
    check("t1_entry_m7", $unsigned(entry), 8'hF9);
    strobe(4'd11);
    check("t1_valid_hi", bus.op_valid, 1'b1);
    check("t1_op_b", $unsigned(bus.op_b), 8'hF9);
    check("t1_entry_opb", $unsigned(entry), 8'hF9);
    tick();
    check("t1_valid_lo", bus.op_valid, 1'b0);
    check("t1_back_a", entering_b, 1'b0);
    check("t1_entry_after", $unsigned(entry), 8'd0);
    check("t1_op_a_hold", $unsigned(bus.op_a), 8'd42);
    check("t1_op_b_hold", $unsigned(bus.op_b), 8'hF9);
    gap(7);

    // Held key yields one digit
    bus.key_code  = 4'd5;
    bus.key_valid = 1'b1;
    gap(20);
    bus.key_valid = 1'b0;
    gap(8);
    check("t2_hold_entry", $unsigned(entry), 8'd5);
    check("t2_hold_cnt", digit_cnt, 2'd1);
    press(4'd11);
    check("t2_op_a5", $unsigned(bus.op_a), 8'd5);
    check("t2_entb", entering_b, 1'b1);

    // Short gaps do not re-arm
    strobe(4'd5); gap(7);
    strobe(4'd5); gap(7);
    strobe(4'd5); gap(8);
    check("t2_gap_entry", $unsigned(entry), 8'd5);
    check("t2_gap_cnt", digit_cnt, 2'd1);

    // Clear in ENTER_B: first clears entry, second backs out
    press(4'd12);
    check("t5_clr1_entry", $unsigned(entry), 8'd0);
    check("t5_clr1_entb", entering_b, 1'b1);
    press(4'd12);
    check("t5_clr2_entb", entering_b, 1'b0);
    check("t5_clr2_op_a", $unsigned(bus.op_a), 8'd0);
    press(4'd11);
    check("t5_empty_enter", entering_b, 1'b0);
    check("t5_empty_cnt", digit_cnt, 2'd0);

    // Overflow on third digit
    press(4'd1);
    press(4'd2);
    press(4'd3);
    check("t3_entry12", $unsigned(entry), 8'd12);
    check("t3_ovf", ovf, 1'b1);
    press(4'd12);
    check("t3_clr_entry", $unsigned(entry), 8'd0);
    check("t3_clr_ovf", ovf, 1'b0);

    // Stalled handoff with keys injected while waiting
    bus.op_ready = 1'b0;
    press(4'd3);
    press(4'd11);
    press(4'd10);
    press(4'd8);
    strobe(4'd11);
    check("t4_valid", bus.op_valid, 1'b1);
    gap(8);
    press(4'd9);
    press(4'd12);
    check("t4_valid_held", bus.op_valid, 1'b1);
    check("t4_op_a", $unsigned(bus.op_a), 8'd3);
    check("t4_op_b", $unsigned(bus.op_b), 8'hF8);
    check("t4_entry", $unsigned(entry), 8'hF8);
    bus.op_ready = 1'b1;
    tick();
    check("t4_xfer_valid", bus.op_valid, 1'b0);
    check("t4_xfer_entb", entering_b, 1'b0);
    check("t4_xfer_entry", $unsigned(entry), 8'd0);

    // Reset during ISSUE
    bus.op_ready = 1'b0;
    press(4'd1);
    press(4'd11);
    press(4'd2);
    press(4'd11);
    check("t6_valid", bus.op_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_valid0", bus.op_valid, 1'b0);
    check("t6_op_a0", $unsigned(bus.op_a), 8'd0);
    check("t6_op_b0", $unsigned(bus.op_b), 8'd0);
    check("t6_entb0", entering_b, 1'b0);
    check("t6_entry0", $unsigned(entry), 8'd0);
    strobe(4'd6);
    check("t6_key_after_rst", $unsigned(entry), 8'd6);
    gap(8);

    // Unused code disarms without other effect
    strobe(4'd13);
    gap(3);
    strobe(4'd7);
    gap(8);
    check("t7_unused_entry", $unsigned(entry), 8'd6);
    check("t7_unused_cnt", digit_cnt, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
